// File: rtl/computational_system.sv
`default_nettype none
// ============================================================================
// Module   : computational_system
// Brief    : Streaming 9-sample sliding-window filter.
//            Y = floor((sum + 9*Xappr)/8), where Xappr is the largest window
//            sample not exceeding the integer window average.
// Revision : 1.0 - initial release
// ============================================================================
module computational_system #(
    parameter int WIN = 9,
    parameter int XW  = 8,
    parameter int YW  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] X,
    output logic [YW-1:0] Y
);

    localparam int SW = 12;  // sum width: 9*255 = 2295
    localparam int TW = 13;  // sum + 9*Xappr: up to 4590

    logic [XW-1:0] win_q [WIN];
    logic [XW-1:0] win_d [WIN];
    logic [SW-1:0] sum_d;
    logic [XW-1:0] xappr_d;
    logic [TW-1:0] total_d;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;

    // Next window: X enters at slot 0, the oldest sample falls off the end.
    always_comb begin
        win_d[0] = X;
        for (int i = 1; i < WIN; i++) begin
            win_d[i] = win_q[i-1];
        end
    end

    // Sum of the post-shift window, which is also what the output reflects.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < WIN; i++) begin
            sum_d = sum_d + SW'(win_d[i]);
        end
    end

    // Largest sample with 9*w <= sum, equivalent to w <= floor(sum/9)
    // without needing a divider. The window minimum always qualifies.
    always_comb begin
        xappr_d = '0;
        for (int i = 0; i < WIN; i++) begin
            if ((SW'(win_d[i]) * SW'(WIN)) <= sum_d && win_d[i] > xappr_d) begin
                xappr_d = win_d[i];
            end
        end
    end

    // Output arithmetic: divide by 8 is a plain truncating right shift.
    always_comb begin
        total_d = TW'(sum_d) + (TW'(xappr_d) * TW'(WIN));
        y_d     = total_d[TW-1:3];
    end

    // Window and result registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
            end
            y_q <= '0;
        end else begin
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= win_d[i];
            end
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_computational_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_computational_system
// Brief    : Self-checking bench for computational_system. A reference model
//            predicts Y on every capturing edge into a queue; the queue is
//            drained and compared on the following falling edge. Directed
//            tasks also compare Y against hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_computational_system;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;

    int total;
    int bad;

    logic [9:0] sb [$];
    logic [7:0] mw [9];

    computational_system #(
        .WIN(9),
        .XW (8),
        .YW (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .X    (X),
        .Y    (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on each capturing edge shift the sample in and push
    // the predicted result; reset empties the window and the queue.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) mw[i] = 8'd0;
            sb.delete();
        end else begin
            int sum;
            int avg;
            int xa;
            for (int i = 8; i > 0; i--) mw[i] = mw[i-1];
            mw[0] = X;
            sum = 0;
            for (int i = 0; i < 9; i++) sum = sum + int'(mw[i]);
            avg = sum / 9;
            xa  = 0;
            for (int i = 0; i < 9; i++) begin
                if (int'(mw[i]) <= avg && int'(mw[i]) > xa) xa = int'(mw[i]);
            end
            sb.push_back(10'((sum + 9 * xa) / 8));
        end
    end

    // Scoreboard drain, half a cycle after each capturing edge.
    always @(negedge clk) begin
        if (!reset && sb.size() > 0) begin
            logic [9:0] exp_y;
            exp_y = sb.pop_front();
            total = total + 1;
            if (Y !== exp_y) begin
                bad = bad + 1;
                $display("FAIL scoreboard t=%0t: Y=%0d expected=%0d", $time, Y, exp_y);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        X     = 8'd0;
        repeat (3) @(negedge clk);
        total = total + 1;
        if (Y !== 10'd0) begin
            bad = bad + 1;
            $display("FAIL reset_state: Y=%0d expected=0", Y);
        end
        reset = 1'b0;
    endtask

    task automatic test_fifty();
        repeat (9) begin
            @(negedge clk);
            X = 8'd50;
        end
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd112) begin
            bad = bad + 1;
            $display("FAIL fifty: Y=%0d expected=112", Y);
        end
    endtask

    task automatic test_ramp();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            X = 8'(i);
        end
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd11) begin
            bad = bad + 1;
            $display("FAIL ramp_1_9: Y=%0d expected=11", Y);
        end
        X = 8'd10;
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd13) begin
            bad = bad + 1;
            $display("FAIL ramp_2_10: Y=%0d expected=13", Y);
        end
    endtask

    task automatic test_below_avg();
        repeat (8) begin
            @(negedge clk);
            X = 8'd0;
        end
        @(negedge clk);
        X = 8'd255;
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd31) begin
            bad = bad + 1;
            $display("FAIL below_avg: Y=%0d expected=31", Y);
        end
    endtask

    task automatic test_max();
        repeat (9) begin
            @(negedge clk);
            X = 8'd255;
        end
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd573) begin
            bad = bad + 1;
            $display("FAIL max: Y=%0d expected=573", Y);
        end
    endtask

    task automatic test_midstream_reset();
        repeat (4) begin
            @(negedge clk);
            X = 8'(70 + $urandom_range(0, 100));
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total = total + 1;
        if (Y !== 10'd0) begin
            bad = bad + 1;
            $display("FAIL async_reset: Y=%0d expected=0", Y);
        end
        @(negedge clk);
        X     = 8'd10;
        reset = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (Y !== 10'd1) begin
            bad = bad + 1;
            $display("FAIL post_reset_first: Y=%0d expected=1", Y);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0:       X = 8'd0;
                1:       X = 8'd255;
                default: X = 8'($urandom_range(0, 255));
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            X = (n % 2 == 0) ? 8'd255 : 8'd0;
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        X     = 8'd0;
        test_reset();
        test_fifty();
        test_ramp();
        test_below_avg();
        test_max();
        test_midstream_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/computational_system.md
Name: computational_system

Overview:
Streaming 9-sample sliding-window filter for the CS (computational system) block. Each clock it accepts one unsigned 8-bit sample X and keeps the 9 most recent samples. It produces a 10-bit result Y = floor((sum + 9*Xappr)/8), where Xappr is the largest window sample not exceeding the integer window average.

Parameters:
- WIN, 9, window length (fixed; the arithmetic widths below assume 9)
- XW, 8, sample width
- YW, 10, result width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- X  input  8  unsigned sample, captured every rising edge
- Y  output  10  unsigned result, registered

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset asserted (any time, including mid-stream):
  - all 9 window registers clear to 0 immediately;
  - Y clears to 0 immediately;
  - state holds while reset stays high.
- Shifting: every rising edge with reset low, X is shifted into the window and the oldest sample is dropped. No enable and no handshake; a sample is taken every cycle.
- Result computation, per edge, on the post-shift window w0..w8 (the 8 newest retained samples plus the current X):
  - sum = w0+...+w8, computed at 12 bits minimum (max 2295).
  - avg = floor(sum/9). Division is optional: the test xi <= avg is equivalent to 9*xi <= sum.
  - Xappr = maximum of all wi with wi <= avg. It always exists because min(w) <= avg. Ties are irrelevant, since only the value matters.
  - Y <= floor((sum + 9*Xappr)/8). The intermediate needs 13 bits (max 4590). Truncate by a right shift of 3. Result max is 573, which fits in 10 bits with no overflow or saturation.
- Latency: the Y value driven after edge k reflects the window whose newest sample is the X captured at edge k. Y therefore changes only just after rising edges and is stable through the rest of the cycle, giving clean setup/hold around the next edge.
- Warm-up: after reset the window holds zeros. The first 8 outputs include zero entries and are still computed by the same rule, with no special casing. Y is fully data-valid from the 9th capture after reset release.
- Samples are unsigned. No rounding beyond floor is applied at either division.

Test Plan:
- Hold reset, then release and feed nine samples 50 -> sum 450, avg 50, Xappr 50, Y = 112 (0x070) after the 9th edge.
- Feed 1,2,...,9 -> sum 45, avg 5, Xappr 5, Y = 11 (0x00B). Then feed 10 -> window 2..10, sum 54, avg 6, Xappr 6, Y = 13 (0x00D).
- Feed eight 0s then 255 -> sum 255, avg 28, Xappr 0, Y = 31 (0x01F). This checks that Xappr selects below-average values.
- Feed nine 255s -> sum 2295, Xappr 255, Y = 573 (0x23D). This checks the maximum and that no overflow occurs.
- Reset mid-stream: assert reset between edges -> Y = 0 without waiting for a clock edge. Release with X = 10 -> after the first edge the window is {10, eight 0s}, sum 10, avg 1, Xappr 0, Y = 1.
- Randomised run of 2000 samples against a reference model of the above formula -> Y must match every cycle from the 9th capture onward.
